// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, exception codes, field positions and
// packing helpers shared by the coprocessor-0 block and its timer.
package cp0_pkg;

  // CP0 register numbers (sel)
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Field positions inside Status / Cause
  localparam int IM_LO        = 10;
  localparam int IM_HI        = 15;
  localparam int IP_LO        = 10;
  localparam int IP_HI        = 15;
  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int CAUSE_BD_BIT = 31;
  localparam int CAUSE_TI_BIT = 30;
  localparam int EXC_CODE_LO  = 2;
  localparam int EXC_CODE_HI  = 6;

  // Number of hardware interrupt bits (IP2..IP7)
  localparam int N_IP = 6;

  // Status register content as seen by MFC0
  function automatic logic [31:0] pack_status(input logic [N_IP-1:0] im,
                                              input logic exl,
                                              input logic ie);
    logic [31:0] r;
    r                = 32'h0000_0000;
    r[IM_HI:IM_LO]   = im;
    r[SR_EXL_BIT]    = exl;
    r[SR_IE_BIT]     = ie;
    return r;
  endfunction

  // Cause register content as seen by MFC0
  function automatic logic [31:0] pack_cause(input logic bd,
                                             input logic ti,
                                             input logic [N_IP-1:0] ip,
                                             input logic [4:0] code);
    logic [31:0] r;
    r                          = 32'h0000_0000;
    r[CAUSE_BD_BIT]            = bd;
    r[CAUSE_TI_BIT]            = ti;
    r[IP_HI:IP_LO]             = ip;
    r[EXC_CODE_HI:EXC_CODE_LO] = code;
    return r;
  endfunction

endpackage

// File: rtl/cp0_timer_core.sv
// cp0_timer_core: free-running Count, Compare and the sticky timer
// interrupt flag TI. Writes arrive already qualified by the parent
// (a flushed instruction never reaches here).
module cp0_timer_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_wen,
  input  logic        compare_wen,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  // Next-state: count up (or load), compare load, TI set on match / clear on Compare write
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_wen) begin
      count_d = din;
    end else begin
      count_d = count_q + 32'd1;
    end
    if (compare_wen) begin
      compare_d = din;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d      = 1'b1;
    end else begin
      ti_d      = ti_q;
    end
  end

  // Timer state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= 32'h0000_0000;
      compare_q <= 32'hFFFF_FFFF;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_timer.sv
// cp0_timer: coprocessor-0 for the multi-cycle MIPS datapath with
// Status/Cause/EPC/PRId, exception entry, ERET and a Count/Compare
// timer feeding IP7.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int          N_HWINT  = 6,
  parameter int          TIMER_EN = 1,
  parameter logic [31:0] PRID     = 32'h0059_756e
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wen,
  input  logic [4:0]         sel,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  input  logic [N_HWINT-1:0] hwint,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic               exc_bd,
  input  logic [29:0]        pc,
  input  logic               eret,
  output logic               int_req,
  output logic [29:0]        epc
);

  // Architectural state
  logic [N_IP-1:0]    im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic [N_HWINT-1:0] ip_hw_q, ip_hw_d;
  logic               bd_q, bd_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [29:0]        epc_q, epc_d;

  // Derived signals
  logic               wen_eff_s;
  logic [31:0]        count_s;
  logic [31:0]        compare_s;
  logic               ti_s;
  logic [N_IP-1:0]    hw_ext_s;
  logic [N_IP-1:0]    ip_s;

  // An exception flushes the instruction issuing MTC0, so its write is dropped
  assign wen_eff_s = wen & ~exc_req;

  generate
    if (TIMER_EN != 0) begin : g_timer
      cp0_timer_core u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_wen   (wen_eff_s && (sel == CP0_COUNT)),
        .compare_wen (wen_eff_s && (sel == CP0_COMPARE)),
        .din         (din),
        .count       (count_s),
        .compare     (compare_s),
        .ti          (ti_s)
      );
    end else begin : g_no_timer
      assign count_s   = 32'h0000_0000;
      assign compare_s = 32'h0000_0000;
      assign ti_s      = 1'b0;
    end
  endgenerate

  // Widen the sampled interrupt lines to the six IP2..IP7 slots; unused slots read 0
  always_comb begin
    hw_ext_s = {N_IP{1'b0}};
    for (int i = 0; i < N_HWINT; i++) begin
      hw_ext_s[i] = ip_hw_q[i];
    end
  end

  // IP7 also carries the timer interrupt
  assign ip_s = {hw_ext_s[N_IP-1] | ti_s, hw_ext_s[N_IP-2:0]};

  assign int_req = (|(ip_s & im_q)) & ie_q & ~exl_q;
  assign epc     = epc_q;

  // Next-state for Status/Cause/EPC: exception beats ERET beats MTC0
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    ip_hw_d    = hwint;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (exc_req) begin
      exl_d      = 1'b1;
      exc_code_d = exc_code;
      if (!exl_q) begin
        // first-level entry records the restart point; nested entry keeps it
        bd_d  = exc_bd;
        epc_d = exc_bd ? (pc - 30'd1) : pc;
      end else begin
        bd_d  = bd_q;
        epc_d = epc_q;
      end
    end else begin
      if (wen && (sel == CP0_SR)) begin
        im_d  = din[IM_HI:IM_LO];
        ie_d  = din[SR_IE_BIT];
        exl_d = din[SR_EXL_BIT];
      end else begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
      end
      if (eret) begin
        // ERET wins over a concurrent EXL write from MTC0
        exl_d = 1'b0;
      end else begin
        exl_d = exl_d;
      end
    end
  end

  // Status/Cause/EPC registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      im_q       <= {N_IP{1'b0}};
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_hw_q    <= {N_HWINT{1'b0}};
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 30'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      ip_hw_q    <= ip_hw_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // MFC0 read mux, combinational from sel
  always_comb begin
    dout = 32'h0000_0000;
    case (sel)
      CP0_SR:      dout = pack_status(im_q, exl_q, ie_q);
      CP0_CAUSE:   dout = pack_cause(bd_q, ti_s, ip_s, exc_code_q);
      CP0_EPC:     dout = {epc_q, 2'b00};
      CP0_PRID:    dout = PRID;
      CP0_COUNT:   dout = count_s;
      CP0_COMPARE: dout = compare_s;
      default:     dout = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer.sv
// tb_cp0_timer: scoreboard bench. The stimulus process pushes the expected
// outputs for each cycle (from a field-level reference model or a constant)
// and a negedge monitor pops and compares against both DUT instances.
module tb_cp0_timer;

  localparam logic [31:0] PRID_C = 32'h0059_756e;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen;
  logic [4:0]  sel;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  hwint;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [29:0] pc;
  logic        eret;
  logic        int_req;
  logic [29:0] epc;

  // second instance: 2 external lines, no timer, never written
  logic        wen2 = 1'b0;
  logic [4:0]  sel2;
  logic [31:0] din2 = 32'h0;
  logic [31:0] dout2;
  logic [1:0]  hwint2;
  logic        exc_req2 = 1'b0;
  logic [4:0]  exc_code2 = 5'd0;
  logic        exc_bd2 = 1'b0;
  logic [29:0] pc2 = 30'd0;
  logic        eret2 = 1'b0;
  logic        int_req2;
  logic [29:0] epc2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp0_timer #(.N_HWINT(6), .TIMER_EN(1), .PRID(PRID_C)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .sel(sel), .din(din), .dout(dout),
    .hwint(hwint), .exc_req(exc_req), .exc_code(exc_code), .exc_bd(exc_bd),
    .pc(pc), .eret(eret), .int_req(int_req), .epc(epc)
  );

  cp0_timer #(.N_HWINT(2), .TIMER_EN(0), .PRID(PRID_C)) dut2 (
    .clk(clk), .rst_n(rst_n), .wen(wen2), .sel(sel2), .din(din2), .dout(dout2),
    .hwint(hwint2), .exc_req(exc_req2), .exc_code(exc_code2), .exc_bd(exc_bd2),
    .pc(pc2), .eret(eret2), .int_req(int_req2), .epc(epc2)
  );

  // ---------------- reference model (architectural fields) ----------------
  logic [5:0]  m_im;
  logic        m_ie, m_exl, m_ti, m_bd;
  logic [5:0]  m_hw;
  logic [4:0]  m_code;
  logic [29:0] m_epc;
  logic [31:0] m_count, m_compare;
  logic [1:0]  m2_hw;

  function automatic logic [5:0] m_ip();
    return {m_ti | m_hw[5], m_hw[4:0]};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
      5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
      5'd13:   return {m_bd, m_ti, 14'h0, m_ip(), 3'h0, m_code, 2'h0};
      5'd14:   return {m_epc, 2'b00};
      5'd15:   return PRID_C;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return (|(m_ip() & m_im)) & m_ie & ~m_exl;
  endfunction

  function automatic logic [31:0] m2_read(input logic [4:0] s);
    case (s)
      5'd13:   return {20'h0, m2_hw, 10'h0};
      5'd15:   return PRID_C;
      default: return 32'h0;
    endcase
  endfunction

  // apply one rising edge to the model using the currently driven inputs
  task automatic model_edge();
    logic wr;
    logic hit;
    if (!rst_n) begin
      m_im = 6'h0; m_ie = 1'b0; m_exl = 1'b0; m_ti = 1'b0; m_bd = 1'b0;
      m_hw = 6'h0; m_code = 5'd0; m_epc = 30'd0;
      m_count = 32'h0; m_compare = 32'hFFFF_FFFF; m2_hw = 2'b00;
    end else begin
      wr    = wen && !exc_req;
      hit   = (m_count == m_compare);
      m_hw  = hwint;
      m2_hw = hwint2;
      if (wr && sel == 5'd11) begin
        m_compare = din;
        m_ti      = 1'b0;
      end else if (hit) begin
        m_ti = 1'b1;
      end
      m_count = (wr && sel == 5'd9) ? din : m_count + 32'd1;
      if (exc_req) begin
        if (!m_exl) begin
          m_bd  = exc_bd;
          m_epc = exc_bd ? pc - 30'd1 : pc;
        end
        m_code = exc_code;
        m_exl  = 1'b1;
      end else begin
        if (wen && sel == 5'd12) begin
          m_im  = din[15:10];
          m_ie  = din[0];
          m_exl = din[1];
        end
        if (eret) m_exl = 1'b0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    string       nm;
    logic [31:0] dout;
    logic        ir;
    logic [29:0] epc;
    logic [31:0] dout2;
    logic        ir2;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // monitor: compare DUT outputs with the oldest expectation each negedge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.nm, "_dout"}, dout, e.dout);
      chk({e.nm, "_int_req"}, {31'h0, int_req}, {31'h0, e.ir});
      chk({e.nm, "_epc"}, {2'b00, epc}, {2'b00, e.epc});
      chk({e.nm, "_dout2"}, dout2, e.dout2);
      chk({e.nm, "_int_req2"}, {31'h0, int_req2}, {31'h0, e.ir2});
      chk({e.nm, "_epc2"}, {2'b00, epc2}, 32'h0);
    end
  end

  // push the expectation for this cycle, then take one clock edge
  task automatic cyc(input string nm, input bit use_c, input logic [31:0] cval);
    exp_t e;
    e.nm    = nm;
    e.dout  = use_c ? cval : m_read(sel);
    e.ir    = m_int();
    e.epc   = m_epc;
    e.dout2 = m2_read(sel2);
    e.ir2   = 1'b0;
    q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
    wen = 1'b0; exc_req = 1'b0; eret = 1'b0;
  endtask

  task automatic rand_inputs();
    wen = 1'($urandom); sel = 5'($urandom); din = $urandom;
    hwint = 6'($urandom); exc_req = 1'($urandom); exc_code = 5'($urandom);
    exc_bd = 1'($urandom); pc = 30'($urandom); eret = 1'($urandom);
    sel2 = 5'($urandom); hwint2 = 2'($urandom);
  endtask

  logic [4:0] sel_tab [6] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

  initial begin
    // reset with random inputs for two edges
    rst_n = 1'b0;
    rand_inputs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      rand_inputs();
    end
    rst_n = 1'b1;
    wen = 1'b0; exc_req = 1'b0; eret = 1'b0; hwint = 6'h0; din = 32'h0;
    exc_code = 5'd0; exc_bd = 1'b0; pc = 30'h0; hwint2 = 2'b11; sel2 = 5'd13;

    // reset values
    sel = 5'd15; cyc("rst_prid", 1, 32'h0059_756e);
    sel = 5'd12; cyc("rst_sr", 1, 32'h0);
    sel = 5'd13; cyc("rst_cause", 1, 32'h0);
    sel = 5'd14; cyc("rst_epc", 1, 32'h0);
    sel = 5'd11; cyc("rst_compare", 1, 32'hFFFF_FFFF);

    // interrupt path
    sel = 5'd12; wen = 1'b1; din = 32'h0000_FC01; cyc("sr_wr", 1, 32'h0);
    sel = 5'd12; hwint = 6'h01;                    cyc("sr_rd", 1, 32'h0000_FC01);
    sel = 5'd13;                                   cyc("ip2", 1, 32'h0000_0400);
    sel = 5'd14; exc_req = 1'b1; exc_code = 5'd0; pc = 30'h100;
    cyc("exc_issue", 1, 32'h0);
    sel = 5'd14; cyc("exc_epc", 1, 32'h0000_0400);
    sel = 5'd12; cyc("exc_exl", 1, 32'h0000_FC03);
    eret = 1'b1; cyc("eret_issue", 1, 32'h0000_FC03);
    cyc("eret_done", 1, 32'h0000_FC01);

    // delay slot and nesting
    sel = 5'd13; exc_req = 1'b1; exc_bd = 1'b1; pc = 30'h0; exc_code = 5'd4;
    cyc("bd_issue", 1, 32'h0000_0400);
    sel = 5'd14; exc_bd = 1'b0; cyc("bd_epc", 1, 32'hFFFF_FFFC);
    sel = 5'd13; cyc("bd_cause", 1, 32'h8000_0410);
    sel = 5'd14; exc_req = 1'b1; exc_code = 5'd12; pc = 30'h55;
    cyc("nest_issue", 1, 32'hFFFF_FFFC);
    sel = 5'd14; cyc("nest_epc", 1, 32'hFFFF_FFFC);
    sel = 5'd13; cyc("nest_cause", 1, 32'h8000_0430);

    // collisions
    sel = 5'd12; exc_req = 1'b1; exc_code = 5'd8; wen = 1'b1; din = 32'h0;
    cyc("exc_wen", 1, 32'h0000_FC03);
    sel = 5'd12; cyc("exc_wen_sr", 1, 32'h0000_FC03);
    eret = 1'b1; wen = 1'b1; din = 32'h0000_0401; cyc("eret_wen", 1, 32'h0000_FC03);
    hwint = 6'h0; cyc("eret_wen_sr", 1, 32'h0000_0401);

    // timer wrap and match
    sel = 5'd9;  wen = 1'b1; din = 32'hFFFF_FFFE; cyc("cnt_wr", 0, 32'h0);
    sel = 5'd11; wen = 1'b1; din = 32'h0000_0001; cyc("cmp_wr", 0, 32'h0);
    sel = 5'd12; wen = 1'b1; din = 32'h0000_8001; cyc("sr_im7", 1, 32'h0000_0401);
    sel = 5'd9;  cyc("cnt_wrap", 1, 32'h0);
    sel = 5'd9;  cyc("cnt_match", 1, 32'h1);
    sel = 5'd13; cyc("ti_set", 1, 32'hC000_8020);
    sel = 5'd11; wen = 1'b1; din = 32'h0000_1000; cyc("cmp_clr", 1, 32'h0000_0001);
    sel = 5'd13; cyc("ti_clr", 1, 32'h8000_0020);

    // randomized phase against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 399) != 0);
      sel      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : sel_tab[$urandom_range(0, 5)];
      wen      = ($urandom_range(0, 3) == 0);
      din      = $urandom;
      if (sel == 5'd11 && $urandom_range(0, 1) == 1) din = m_count + 32'($urandom_range(0, 4));
      exc_req  = ($urandom_range(0, 11) == 0);
      exc_code = 5'($urandom);
      exc_bd   = 1'($urandom);
      pc       = 30'($urandom);
      eret     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) hwint = 6'($urandom);
      sel2     = sel_tab[$urandom_range(0, 5)];
      hwint2   = 2'($urandom);
      cyc("rand", 0, 32'h0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
